sensor_scan_mux: RTL and testbench
==================================

SENSOR_SCAN_MUX -- requirements
Module: sensor_scan_mux

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CH, 4, number of input channels, legal range 2..16.
- W, 8, data width per channel in bits.
- DWELL, 4, clock cycles spent on each channel in scan mode, legal range >= 1.
- SW = ceil(log2(CH)), derived, selector and channel-index width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock; all state SHALL update on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, block enable.
- mode, in, 1, 0 = manual select, 1 = automatic scan.
- sel, in, SW, manual channel select.
- hold, in, 1, freeze the scan in scan mode.
- din, in, CH*W, packed channels; channel k is din[k*W +: W].
- dout, out, W, registered selected sample.
- ch_out, out, SW, channel index of the current dout.
- valid, out, 1, one-cycle strobe: new sample on dout.
- frame_done, out, 1, one-cycle strobe: last channel of a scan sampled.
- sel_err, out, 1, registered flag: manual sel >= CH.

Function
REQ-003 The FSM SHALL have three states: IDLE, MANUAL and SCAN.
REQ-004 State transitions SHALL be evaluated every cycle in this order:
- en = 0 -> IDLE.
- en = 1, mode = 0 -> MANUAL.
- en = 1, mode = 1 -> SCAN.
REQ-005 IDLE SHALL behave as follows:
- dout and ch_out keep their values.
- valid, frame_done and sel_err are 0.
- The scan pointer and dwell counter are cleared to 0.
REQ-006 MANUAL with sel < CH: each cycle the block SHALL register din[sel] into dout and sel into ch_out, and drive valid = 1 and sel_err = 0. Latency is one cycle from sel/din to dout.
REQ-007 MANUAL with sel >= CH: dout SHALL be 0, ch_out SHALL be sel, valid SHALL be 0 and sel_err SHALL be 1.
REQ-008 SCAN SHALL use a pointer ptr (SW bits) and a dwell counter cnt (0..DWELL-1), both 0 on entry to SCAN from any other state.
REQ-009 In SCAN with hold = 0, when cnt < DWELL-1, the block SHALL increment cnt, and valid and frame_done SHALL be 0.
REQ-010 In SCAN with hold = 0, when cnt = DWELL-1, the block SHALL do all of the following in the same cycle:
- Register din[ptr] into dout and ptr into ch_out.
- Pulse valid for one cycle.
- Clear cnt to 0.
- Advance ptr.
REQ-011 ptr SHALL advance by 1, and SHALL wrap from CH-1 to 0 (not to 2^SW-1) when CH is not a power of two.
REQ-012 frame_done SHALL pulse together with valid whenever the sampled channel is CH-1.
REQ-013 In SCAN with hold = 1, ptr, cnt, dout and ch_out SHALL freeze, and valid and frame_done SHALL be 0; when hold is released the dwell SHALL resume from the frozen cnt.
REQ-014 With DWELL = 1, valid SHALL pulse every non-held cycle and ptr SHALL advance every cycle.
REQ-015 A switch from MANUAL to SCAN SHALL restart the scan at ptr = 0, cnt = 0; the first scan valid SHALL occur DWELL cycles after the switch.
REQ-016 A switch from SCAN to MANUAL SHALL take effect on the next edge; no pending scan valid SHALL be issued.
REQ-017 sel_err SHALL be 0 in every state except MANUAL.
REQ-018 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-019 rst_n = 0 SHALL immediately, independent of clk, force:
- state = IDLE, ptr = 0, cnt = 0.
- dout = 0, ch_out = 0.
- valid = 0, frame_done = 0, sel_err = 0.
REQ-020 Reset asserted mid-scan SHALL abort the dwell; after release the block SHALL behave as if it had just been enabled.
REQ-021 Reset deassertion SHALL be used synchronously to clk for state updates; the first update SHALL occur on the first rising edge with rst_n = 1.

Verification
REQ-022 Manual select: CH = 4, W = 8, din = {8'h44, 8'h33, 8'h22, 8'h11}, mode = 0, en = 1, sel = 2 -> one cycle later dout = 8'h33, ch_out = 2, valid = 1 every cycle.
REQ-023 Scan and wrap: CH = 4, DWELL = 4, mode = 1 -> valid pulses every 4 cycles with ch_out = 0, 1, 2, 3, 0; frame_done accompanies ch_out = 3 only.
REQ-024 Non-power-of-two channel count: CH = 3, DWELL = 1 -> ch_out sequence 0, 1, 2, 0, 1; frame_done every third valid; ch_out never equals 3.
REQ-025 Hold: assert hold at cnt = 2 on channel 1 for 5 cycles -> no valid during hold; channel 1 valid occurs exactly 2 cycles after hold release.
REQ-026 Out-of-range select: CH = 3, mode = 0, sel = 3 -> dout = 0, sel_err = 1, valid = 0; then sel = 1 -> sel_err = 0, dout = din ch1.
REQ-027 Asynchronous reset: pull rst_n low mid-dwell between clock edges -> all outputs 0 before the next edge; after release with mode = 1, the first valid has ch_out = 0 after DWELL cycles.

Source files
------------

// File: rtl/sensor_scan_mux.sv
// Sensor channel multiplexer with a manual select mode and an automatic
// round-robin scan mode that dwells a fixed number of cycles per channel.
module sensor_scan_mux #(
    parameter  int CH    = 4,
    parameter  int W     = 8,
    parameter  int DWELL = 4,
    localparam int SW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic            hold,
    input  logic [CH*W-1:0] din,
    output logic [W-1:0]    dout,
    output logic [SW-1:0]   ch_out,
    output logic            valid,
    output logic            frame_done,
    output logic            sel_err
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);
    localparam logic [SW-1:0] LAST_CH  = SW'(CH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  dout_q, dout_d;
    logic [SW-1:0] ch_out_q, ch_out_d;
    logic          valid_q, valid_d;
    logic          frame_done_q, frame_done_d;
    logic          sel_err_q, sel_err_d;

    logic [SW-1:0] scan_ptr;
    logic [CW-1:0] scan_cnt;
    logic [W-1:0]  sel_data;
    logic [W-1:0]  ptr_data;
    logic          sel_ok;

    // The state chosen for this edge is the one whose action is taken on it,
    // so a mode or enable change is visible on the very next edge.
    always_comb begin
        if (!en) begin
            state_d = IDLE;
        end else if (!mode) begin
            state_d = MANUAL;
        end else begin
            state_d = SCAN;
        end
    end

    // Entering SCAN from another state always restarts at channel 0, count 0.
    always_comb begin
        if (state_q == SCAN) begin
            scan_ptr = ptr_q;
            scan_cnt = cnt_q;
        end else begin
            scan_ptr = '0;
            scan_cnt = '0;
        end
    end

    assign sel_ok = (int'(sel) < CH);

    // Only channels 0..CH-1 are decoded; unused selector codes read as zero.
    always_comb begin
        sel_data = '0;
        ptr_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (sel == SW'(k)) begin
                sel_data = din[k*W +: W];
            end
            if (scan_ptr == SW'(k)) begin
                ptr_data = din[k*W +: W];
            end
        end
    end

    always_comb begin
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        ch_out_d     = ch_out_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;
        sel_err_d    = 1'b0;

        case (state_d)
            IDLE: begin
                ptr_d = '0;
                cnt_d = '0;
            end

            MANUAL: begin
                ptr_d    = '0;
                cnt_d    = '0;
                ch_out_d = sel;
                if (sel_ok) begin
                    dout_d  = sel_data;
                    valid_d = 1'b1;
                end else begin
                    dout_d    = '0;
                    sel_err_d = 1'b1;
                end
            end

            SCAN: begin
                ptr_d = scan_ptr;
                cnt_d = scan_cnt;
                if (!hold) begin
                    if (scan_cnt == LAST_CNT) begin
                        dout_d       = ptr_data;
                        ch_out_d     = scan_ptr;
                        valid_d      = 1'b1;
                        frame_done_d = (scan_ptr == LAST_CH);
                        cnt_d        = '0;
                        ptr_d        = (scan_ptr == LAST_CH) ? '0 : scan_ptr + SW'(1);
                    end else begin
                        cnt_d = scan_cnt + CW'(1);
                    end
                end
            end

            default: begin
                ptr_d = '0;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            ch_out_q     <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            ch_out_q     <= ch_out_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            sel_err_q    <= sel_err_d;
        end
    end

    // valid is a single-cycle strobe with no back-pressure: a consumer must
    // capture dout/ch_out in the cycle valid is high.
    assign dout       = dout_q;
    assign ch_out     = ch_out_q;
    assign valid      = valid_q;
    assign frame_done = frame_done_q;
    assign sel_err    = sel_err_q;

    a_valid_err_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(valid_q && sel_err_q));

    a_frame_needs_valid : assert property (@(posedge clk) disable iff (!rst_n)
        frame_done_q |-> valid_q);

    a_valid_ch_range : assert property (@(posedge clk) disable iff (!rst_n)
        valid_q |-> (int'(ch_out_q) < CH));

endmodule

// File: tb/tb_sensor_scan_mux.sv
// Bench for sensor_scan_mux: a 4-channel/dwell-4 and a 3-channel/dwell-1
// instance, checked every cycle against a scan-age model plus literal cases.
module tb_sensor_scan_mux;

    logic clk;
    logic rst_n = 1'b0;

    logic        en0 = 0, mode0 = 0, hold0 = 0;
    logic [1:0]  sel0 = '0;
    logic [31:0] din0 = '0;
    logic [7:0]  dout0;
    logic [1:0]  ch0;
    logic        valid0, fd0, err0;

    logic        en1 = 0, mode1 = 0, hold1 = 0;
    logic [1:0]  sel1 = '0;
    logic [23:0] din1 = '0;
    logic [7:0]  dout1;
    logic [1:0]  ch1;
    logic        valid1, fd1, err1;

    int checks = 0;
    int errors = 0;

    int         m_age[2]   = '{0, 0};
    logic [7:0] m_dout[2]  = '{8'h0, 8'h0};
    int         m_ch[2]    = '{0, 0};
    logic       m_valid[2] = '{1'b0, 1'b0};
    logic       m_fd[2]    = '{1'b0, 1'b0};
    logic       m_err[2]   = '{1'b0, 1'b0};

    sensor_scan_mux #(.CH(4), .W(8), .DWELL(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .mode(mode0), .sel(sel0), .hold(hold0),
        .din(din0), .dout(dout0), .ch_out(ch0), .valid(valid0),
        .frame_done(fd0), .sel_err(err0)
    );

    sensor_scan_mux #(.CH(3), .W(8), .DWELL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .sel(sel1), .hold(hold1),
        .din(din1), .dout(dout1), .ch_out(ch1), .valid(valid1),
        .frame_done(fd1), .sel_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_age[i]   = 0;
        m_dout[i]  = '0;
        m_ch[i]    = 0;
        m_valid[i] = 1'b0;
        m_fd[i]    = 1'b0;
        m_err[i]   = 1'b0;
    endtask

    // Scan position is derived from how many non-held scan cycles have elapsed
    // since the scan started: every dw-th one samples the next channel.
    task automatic model_step(input int i, input int nch, input int dw, input logic en,
                              input logic mode, input int sel, input logic hold,
                              input logic [31:0] din);
        int c;
        m_valid[i] = 1'b0;
        m_fd[i]    = 1'b0;
        m_err[i]   = 1'b0;
        if (!en) begin
            m_age[i] = 0;
        end else if (!mode) begin
            m_age[i] = 0;
            m_ch[i]  = sel;
            if (sel < nch) begin
                m_dout[i]  = din[sel*8 +: 8];
                m_valid[i] = 1'b1;
            end else begin
                m_dout[i] = '0;
                m_err[i]  = 1'b1;
            end
        end else if (!hold) begin
            m_age[i]++;
            if (m_age[i] % dw == 0) begin
                c          = (m_age[i] / dw - 1) % nch;
                m_dout[i]  = din[c*8 +: 8];
                m_ch[i]    = c;
                m_valid[i] = 1'b1;
                m_fd[i]    = (c == nch - 1);
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, 4, 4, en0, mode0, int'(sel0), hold0, din0);
            model_step(1, 3, 1, en1, mode1, int'(sel1), hold1, {8'h0, din1});
        end
        #1;
        chk("m0 dout", dout0, m_dout[0]);
        chk("m0 ch_out", ch0, m_ch[0]);
        chk("m0 valid", valid0, m_valid[0]);
        chk("m0 frame_done", fd0, m_fd[0]);
        chk("m0 sel_err", err0, m_err[0]);
        chk("m1 dout", dout1, m_dout[1]);
        chk("m1 ch_out", ch1, m_ch[1]);
        chk("m1 valid", valid1, m_valid[1]);
        chk("m1 frame_done", fd1, m_fd[1]);
        chk("m1 sel_err", err1, m_err[1]);
    end

    int exp_scan4[5] = '{0, 1, 2, 3, 0};
    int exp_scan3[6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        repeat (3) @(negedge clk);
        chk("reset dout", dout0, 8'h00);
        chk("reset ch_out", ch0, 2'd0);
        chk("reset valid", valid0, 1'b0);
        chk("reset sel_err", err0, 1'b0);

        // Manual select of channel 2
        rst_n = 1'b1;
        en0 = 1; mode0 = 0; sel0 = 2'd2; din0 = 32'h44332211;
        @(negedge clk);
        chk("manual dout", dout0, 8'h33);
        chk("manual ch_out", ch0, 2'd2);
        chk("manual valid", valid0, 1'b1);
        @(negedge clk);
        chk("manual valid again", valid0, 1'b1);

        // Scan with wrap
        mode0 = 1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk("scan valid", valid0, (i % 4 == 0));
            chk("scan frame_done", fd0, (i == 16));
            if (i % 4 == 0) chk("scan ch_out", ch0, exp_scan4[i/4 - 1]);
        end

        // Hold at count 2 on channel 1 for five cycles
        repeat (2) @(negedge clk);
        hold0 = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold valid", valid0, 1'b0);
        end
        hold0 = 0;
        @(negedge clk);
        chk("release+1 valid", valid0, 1'b0);
        @(negedge clk);
        chk("release+2 valid", valid0, 1'b1);
        chk("release+2 ch_out", ch0, 2'd1);
        chk("release+2 dout", dout0, 8'h22);

        // Scan to manual with a sample pending: manual wins on the next edge
        repeat (3) @(negedge clk);
        mode0 = 0; sel0 = 2'd3;
        @(negedge clk);
        chk("to manual ch_out", ch0, 2'd3);
        chk("to manual dout", dout0, 8'h44);
        chk("to manual frame_done", fd0, 1'b0);

        // Manual to scan restarts at channel 0
        mode0 = 1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("restart valid", valid0, (i == 4));
        end
        chk("restart ch_out", ch0, 2'd0);
        chk("restart dout", dout0, 8'h11);

        // Asynchronous reset mid-dwell
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async dout", dout0, 8'h00);
        chk("async ch_out", ch0, 2'd0);
        chk("async valid", valid0, 1'b0);
        chk("async frame_done", fd0, 1'b0);
        chk("async sel_err", err0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("post-reset valid", valid0, (i == 4));
        end
        chk("post-reset ch_out", ch0, 2'd0);

        // Three-channel instance: out-of-range select, then dwell-1 scan
        en0 = 0;
        en1 = 1; mode1 = 0; sel1 = 2'd3; din1 = 24'h332211;
        @(negedge clk);
        chk("oor dout", dout1, 8'h00);
        chk("oor sel_err", err1, 1'b1);
        chk("oor valid", valid1, 1'b0);
        chk("oor ch_out", ch1, 2'd3);
        sel1 = 2'd1;
        @(negedge clk);
        chk("inrange sel_err", err1, 1'b0);
        chk("inrange dout", dout1, 8'h22);
        chk("inrange valid", valid1, 1'b1);
        mode1 = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("ch3 valid", valid1, 1'b1);
            chk("ch3 ch_out", ch1, exp_scan3[i]);
            chk("ch3 frame_done", fd1, (i % 3 == 2));
            chk("ch3 ch_out not 3", (ch1 != 2'd3), 1'b1);
        end

        // Randomized traffic, checked by the model process
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            en0   = ($urandom_range(0, 9) != 0);
            en1   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) mode0 = ~mode0;
            if ($urandom_range(0, 7) == 0) mode1 = ~mode1;
            hold0 = ($urandom_range(0, 5) == 0);
            hold1 = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) sel0 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) sel1 = 2'($urandom_range(0, 3));
            din0 = $urandom;
            din1 = 24'($urandom);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
